// File: rtl/p_pipe_pkg.sv
// p_pipe shared definitions.
// Parameter defaults and occupancy width helper.
package p_pipe_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int LANES_DEF = 1;
  localparam int DEPTH_DEF = 2;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/p_pipe_stage.sv
// One pipeline stage: main register plus skid register.
// Upstream ready is the registered "skid empty" flag.
module p_pipe_stage #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          mv;
  logic          sv;
  logic [DW-1:0] md;
  logic [DW-1:0] sd;
  logic          take_in;
  logic          take_out;

  assign up_ready = ~sv;
  assign dn_valid = mv;
  assign dn_data  = md;
  assign take_in  = up_valid & ~sv;
  assign take_out = mv & dn_ready;

  // sv implies mv, and take_in implies ~sv, so the arms are disjoint
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mv <= 1'b0;
      sv <= 1'b0;
    end else begin
      unique case (1'b1)
        take_out && sv: begin
          md <= sd;
          sv <= 1'b0;
        end
        take_out && take_in: begin
          md <= up_data;
        end
        take_out && !sv && !take_in: begin
          mv <= 1'b0;
        end
        take_in && mv && !take_out: begin
          sd <= up_data;
          sv <= 1'b1;
        end
        take_in && !mv: begin
          md <= up_data;
          mv <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/p_pipe_chain.sv
// Multi-lane valid/ready pipeline of DEPTH skid stages.
// Tracks words held in an occupancy counter.
module p_pipe_chain
  import p_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int DW = LANES * WIDTH;
  localparam int OW = occ_width(DEPTH);

  logic [DEPTH:0] v;
  logic [DEPTH:0] r;
  logic [DW-1:0]  d [DEPTH+1];
  logic           in_fire;
  logic           out_fire;

  assign v[0]     = in_valid;
  assign d[0]     = in_data;
  assign r[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    p_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (v[i]),
      .up_ready (r[i]),
      .up_data  (d[i]),
      .dn_valid (v[i+1]),
      .dn_ready (r[i+1]),
      .dn_data  (d[i+1])
    );
  end

  assign in_ready  = r[0] & ~rst;
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_p_pipe_chain.sv
// Bench for p_pipe_chain: vector table plus directed
// backpressure/streaming sequences and random scoreboarding.
module tb_p_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;

  logic        iv0, ir0, ov0, or0;
  logic [15:0] id0, od0;
  logic [2:0]  oc0;

  logic        iv1, ir1, ov1, or1;
  logic [0:0]  id1, od1;
  logic [1:0]  oc1;

  logic        iv2, ir2, ov2, or2;
  logic [11:0] id2, od2;
  logic [3:0]  oc2;

  logic        fl_off;

  p_pipe_chain #(
    .WIDTH(8), .LANES(2), .DEPTH(3)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(oc0)
  );

  p_pipe_chain #(
    .WIDTH(1), .LANES(1), .DEPTH(1)
  ) u1 (
    .clk(clk), .rst(rst), .flush(fl_off),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .occupancy(oc1)
  );

  p_pipe_chain #(
    .WIDTH(3), .LANES(4), .DEPTH(5)
  ) u2 (
    .clk(clk), .rst(rst), .flush(fl_off),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .occupancy(oc2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        chk;
    logic        ir;
    logic        ov;
    logic [15:0] od;
    logic [2:0]  occ;
  } vec_t;

  vec_t tbl[14];

  logic [0:0]  q1[$];
  logic [11:0] q2[$];

  initial begin
    rst = 1'b1; flush = 1'b0; fl_off = 1'b0;
    iv0 = 1'b1; id0 = 16'h1111; or0 = 1'b1;
    iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    iv2 = 1'b0; id2 = '0; or2 = 1'b0;

    // rst flush iv data ordy | chk ir ov od occ
    tbl[0]  = '{1, 0, 1, 16'h1111, 1, 0, 0, 0, 16'h0000, 0};
    tbl[1]  = '{1, 0, 1, 16'h1111, 1, 1, 0, 0, 16'h0000, 0};
    tbl[2]  = '{0, 0, 1, 16'hA5C3, 1, 1, 1, 0, 16'h0000, 0};
    tbl[3]  = '{0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 1};
    tbl[4]  = '{0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 1};
    tbl[5]  = '{0, 0, 0, 16'h0000, 1, 1, 1, 1, 16'hA5C3, 1};
    tbl[6]  = '{0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0};
    tbl[7]  = '{0, 0, 1, 16'h0001, 0, 1, 1, 0, 16'h0000, 0};
    tbl[8]  = '{0, 0, 1, 16'h0002, 0, 1, 1, 0, 16'h0000, 1};
    tbl[9]  = '{0, 0, 1, 16'h0003, 0, 1, 1, 0, 16'h0000, 2};
    tbl[10] = '{0, 0, 1, 16'h0004, 0, 1, 1, 1, 16'h0001, 3};
    tbl[11] = '{0, 1, 1, 16'h0005, 0, 1, 1, 1, 16'h0001, 4};
    tbl[12] = '{0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0};
    tbl[13] = '{0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst   = tbl[i].rst;
      flush = tbl[i].flush;
      iv0   = tbl[i].iv;
      id0   = tbl[i].d;
      or0   = tbl[i].ordy;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.in_ready", i), 32'(ir0), 32'(tbl[i].ir));
        chk($sformatf("v%0d.out_valid", i), 32'(ov0), 32'(tbl[i].ov));
        chk($sformatf("v%0d.occupancy", i), 32'(oc0), 32'(tbl[i].occ));
        if (tbl[i].ov)
          chk($sformatf("v%0d.out_data", i), 32'(od0), 32'(tbl[i].od));
      end
    end

    begin : backpressure
      int acc;
      logic [15:0] nxt;
      acc = 0;
      nxt = 16'd1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        iv0 = 1'b1; id0 = nxt; or0 = 1'b0;
        #1;
        if (ir0) begin
          acc++;
          nxt++;
        end
      end
      @(negedge clk);
      iv0 = 1'b0;
      #1;
      chk("bp.accepted", 32'(acc), 32'd6);
      chk("bp.in_ready", 32'(ir0), 32'd0);
      chk("bp.occupancy", 32'(oc0), 32'd6);
      for (int k = 1; k <= 6; k++) begin
        if (k > 1) @(negedge clk);
        or0 = 1'b1;
        #1;
        chk($sformatf("bp.out_valid%0d", k), 32'(ov0), 32'd1);
        chk($sformatf("bp.out_data%0d", k), 32'(od0), 32'(k));
      end
      @(negedge clk);
      #1;
      chk("bp.drained_valid", 32'(ov0), 32'd0);
      chk("bp.drained_occ", 32'(oc0), 32'd0);
    end

    begin : streaming
      int sent;
      int got;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 300 && got < 100; c++) begin
        @(negedge clk);
        iv0 = (sent < 100);
        id0 = 16'h1000 + 16'(sent);
        or0 = 1'b1;
        #1;
        if (got > 0) chk("st.nobubble", 32'(ov0), 32'd1);
        if (ov0 && iv0) chk("st.occupancy", 32'(oc0), 32'd3);
        if (ov0) begin
          chk("st.data", 32'(od0), 32'h1000 + 32'(got));
          got++;
        end
        if (iv0 && ir0) sent++;
      end
      chk("st.count", 32'(got), 32'd100);
      @(negedge clk);
      iv0 = 1'b0;
      #1;
      chk("st.final_occ", 32'(oc0), 32'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      iv1 = 1'($urandom_range(0, 1));
      id1 = 1'($urandom);
      or1 = 1'($urandom_range(0, 1));
      iv2 = ($urandom_range(0, 3) != 0);
      id2 = 12'($urandom);
      or2 = ($urandom_range(0, 2) == 0);
      #1;
      chk("r1.occupancy", 32'(oc1), 32'(q1.size()));
      chk("r1.bound", 32'(q1.size() <= 2), 32'd1);
      chk("r2.occupancy", 32'(oc2), 32'(q2.size()));
      chk("r2.bound", 32'(q2.size() <= 10), 32'd1);
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          chk("r1.underflow", 32'(ov1), 32'd0);
        end else begin
          logic [0:0] e1;
          e1 = q1.pop_front();
          chk("r1.data", 32'(od1), 32'(e1));
        end
      end
      if (iv1 && ir1) q1.push_back(id1);
      if (ov2 && or2) begin
        if (q2.size() == 0) begin
          chk("r2.underflow", 32'(ov2), 32'd0);
        end else begin
          logic [11:0] e2;
          e2 = q2.pop_front();
          chk("r2.data", 32'(od2), 32'(e2));
        end
      end
      if (iv2 && ir2) q2.push_back(id2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
